// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand stage: default datapath width,
// opcode encodings, the stage FSM state type and a small opcode helper.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADC  = 3'd1,
    OP_SUB  = 3'd2,
    OP_SBC  = 3'd3,
    OP_NEG  = 3'd4,
    OP_CMP  = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // True for opcodes whose carry-in comes from the architectural carry.
  function automatic logic op_uses_carry(input alu_op_e op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/alu_operand_mux.sv
// -----------------------------------------------------------------------------
// alu_operand_mux
// Combinational operand formation: maps (op, a, b, c) onto the adder inputs.
// Subtraction-style ops invert b and supply the +1 through the carry-in, so a
// plain adder computes a - b.
// Ports:
//   op       opcode (reserved codes behave as ADD)
//   a, b     raw operands, N bits
//   c        effective carry used by ADC / SBC
//   mux_a    adder operand A
//   mux_b    adder operand B
//   mux_cin  adder carry-in
//   mux_cmp  operation is CMP (flags-only)
// -----------------------------------------------------------------------------
module alu_operand_mux
  import alu_pkg::*;
#(
  parameter int N = ALU_WIDTH
) (
  input  alu_op_e      op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c,
  output logic [N-1:0] mux_a,
  output logic [N-1:0] mux_b,
  output logic         mux_cin,
  output logic         mux_cmp
);

  // Opcode-driven selection of adder operands and carry-in.
  always_comb begin
    mux_a   = a;
    mux_b   = b;
    mux_cin = 1'b0;
    mux_cmp = 1'b0;
    case (op)
      OP_ADD: begin
        mux_cin = 1'b0;
      end
      OP_ADC: begin
        mux_cin = c;
      end
      OP_SUB: begin
        mux_b   = ~b;
        mux_cin = 1'b1;
      end
      OP_CMP: begin
        mux_b   = ~b;
        mux_cin = 1'b1;
        mux_cmp = 1'b1;
      end
      OP_SBC: begin
        mux_b   = ~b;
        mux_cin = c;
      end
      OP_NEG: begin
        mux_a   = {N{1'b0}};
        mux_b   = ~b;
        mux_cin = 1'b1;
      end
      default: begin
        // Reserved encodings execute as ADD.
        mux_a   = a;
        mux_b   = b;
        mux_cin = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
// One-entry valid/ready operand register in front of an external adder.
// Accepted requests are mapped to adder operands and held until downstream
// consumes the result; on consumption the adder carry-out is written into the
// architectural carry flag.
// Optional feature macro: ALU_OPERAND_CARRY_FWD_EN
//   defined   : ADC/SBC may be accepted in the cycle the previous op completes,
//               taking the carry directly from add_cout.
//   undefined : ADC/SBC are only accepted from EMPTY and use carry_flag.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake
//   in_op, in_a, in_b      opcode and raw operands
//   out_valid/out_ready    held-operand handshake with the adder consumer
//   add_a, add_b, add_cin  registered adder inputs
//   add_cout               adder carry-out (combinational from adder)
//   out_cmp                held op is CMP (flags only)
//   carry_flag             architectural carry register
// -----------------------------------------------------------------------------
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int N = ALU_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic         add_cout,
  output logic         out_cmp,
  output logic         carry_flag
);

  stage_state_e state_r;
  stage_state_e state_next_s;

  alu_op_e      op_s;
  logic         complete_s;
  logic         transfer_s;
  logic         carry_eff_s;
  logic         carry_block_s;
  logic         in_ready_s;
  logic         out_valid_s;

  logic [N-1:0] mux_a_s;
  logic [N-1:0] mux_b_s;
  logic         mux_cin_s;
  logic         mux_cmp_s;

  logic [N-1:0] add_a_r;
  logic [N-1:0] add_b_r;
  logic         add_cin_r;
  logic         out_cmp_r;
  logic         carry_flag_r;

  assign op_s       = alu_op_e'(in_op);
  assign transfer_s = in_valid && in_ready_s;

  // Completion detect and selection of the carry that feeds ADC/SBC.
  always_comb begin
    complete_s = (state_r == ST_FULL) && out_ready;
`ifdef ALU_OPERAND_CARRY_FWD_EN
    // The flag is being rewritten this edge, so bypass it with add_cout.
    if (complete_s) begin
      carry_eff_s = add_cout;
    end else begin
      carry_eff_s = carry_flag_r;
    end
    carry_block_s = 1'b0;
`else
    // Without the bypass, carry consumers wait until the flag has settled.
    carry_eff_s   = carry_flag_r;
    carry_block_s = (state_r == ST_FULL) && op_uses_carry(op_s);
`endif
  end

  alu_operand_mux #(
    .N(N)
  ) u_mux (
    .op      (op_s),
    .a       (in_a),
    .b       (in_b),
    .c       (carry_eff_s),
    .mux_a   (mux_a_s),
    .mux_b   (mux_b_s),
    .mux_cin (mux_cin_s),
    .mux_cmp (mux_cmp_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (transfer_s) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (complete_s && !transfer_s) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: begin
        state_next_s = ST_EMPTY;
      end
    endcase
  end

  // FSM outputs: handshake signals.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
      ST_FULL: begin
        in_ready_s  = out_ready && !carry_block_s;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Operand holding registers and architectural carry flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a_r      <= {N{1'b0}};
      add_b_r      <= {N{1'b0}};
      add_cin_r    <= 1'b0;
      out_cmp_r    <= 1'b0;
      carry_flag_r <= 1'b0;
    end else begin
      if (transfer_s) begin
        add_a_r   <= mux_a_s;
        add_b_r   <= mux_b_s;
        add_cin_r <= mux_cin_s;
        out_cmp_r <= mux_cmp_s;
      end else begin
        add_a_r   <= add_a_r;
        add_b_r   <= add_b_r;
        add_cin_r <= add_cin_r;
        out_cmp_r <= out_cmp_r;
      end
      if (complete_s) begin
        carry_flag_r <= add_cout;
      end else begin
        carry_flag_r <= carry_flag_r;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign add_a      = add_a_r;
  assign add_b      = add_b_r;
  assign add_cin    = add_cin_r;
  assign out_cmp    = out_cmp_r;
  assign carry_flag = carry_flag_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed bench for alu_operand_stage with an ideal N-bit adder model
// closing the add_cout loop. Build with or without ALU_OPERAND_CARRY_FWD_EN.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic         add_cout;
  logic         out_cmp;
  logic         carry_flag;
  logic [N:0]   sum;

  int errors = 0;
  int checks = 0;

  alu_operand_stage #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_cout   (add_cout),
    .out_cmp    (out_cmp),
    .carry_flag (carry_flag)
  );

  // Ideal adder downstream of the stage.
  assign sum      = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
  assign add_cout = sum[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are read here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic ordy);
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0) begin errors++; $display("FAIL reset_operands: got %h %h %b expected 0 0 0", add_a, add_b, add_cin); end
    checks++; if (out_cmp !== 1'b0 || carry_flag !== 1'b0) begin errors++; $display("FAIL reset_flags: got cmp=%b c=%b expected 0 0", out_cmp, carry_flag); end
  endtask

  task automatic test_sub();
    drive(1'b1, 3'd2, 32'd5, 32'd3, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sub_in_ready: got %b expected 1", in_ready); end
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_out_valid: got %b expected 1", out_valid); end
    checks++; if (add_a !== 32'd5 || add_b !== 32'hFFFF_FFFC || add_cin !== 1'b1) begin errors++; $display("FAIL sub_operands: got %h %h %b expected 00000005 fffffffc 1", add_a, add_b, add_cin); end
    step();
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL sub_carry: got %b expected 1", carry_flag); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain: got %b expected 0", out_valid); end
  endtask

  // Hold a CMP (3 - 5, carry-out 0) with out_ready low; carry_flag is 1 here.
  task automatic test_stall();
    drive(1'b1, 3'd5, 32'd3, 32'd5, 1'b0);
    step();
    drive(1'b1, 3'd0, 32'd7, 32'd8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_cmp !== 1'b1 || carry_flag !== 1'b1) begin errors++; $display("FAIL stall_flags[%0d]: got v=%b cmp=%b c=%b expected 1 1 1", i, out_valid, out_cmp, carry_flag); end
      checks++; if (add_a !== 32'd3 || add_b !== 32'hFFFF_FFFA || add_cin !== 1'b1) begin errors++; $display("FAIL stall_operands[%0d]: got %h %h %b expected 00000003 fffffffa 1", i, add_a, add_b, add_cin); end
      step();
    end
    drive(1'b1, 3'd0, 32'd7, 32'd8, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    checks++; if (out_valid !== 1'b1 || add_a !== 32'd7 || add_b !== 32'd8 || add_cin !== 1'b0 || out_cmp !== 1'b0) begin errors++; $display("FAIL b2b_operands: got v=%b %h %h %b cmp=%b expected 1 00000007 00000008 0 0", out_valid, add_a, add_b, add_cin, out_cmp); end
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL b2b_cmp_carry: got %b expected 0", carry_flag); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_neg();
    drive(1'b1, 3'd4, 32'h0000_1234, 32'd1, 1'b1);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    checks++; if (add_a !== 32'd0 || add_b !== 32'hFFFF_FFFE || add_cin !== 1'b1) begin errors++; $display("FAIL neg_operands: got %h %h %b expected 00000000 fffffffe 1", add_a, add_b, add_cin); end
    step();
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL neg_carry: got %b expected 0", carry_flag); end
  endtask

  task automatic test_carry_fwd();
    drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step();
    drive(1'b1, 3'd1, 32'd0, 32'd0, 1'b1);
`ifdef ALU_OPERAND_CARRY_FWD_EN
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_in_ready: got %b expected 1", in_ready); end
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
`else
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fwd_block: got %b expected 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL fwd_unblock: got rdy=%b v=%b expected 1 0", in_ready, out_valid); end
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
`endif
    checks++; if (out_valid !== 1'b1 || add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b1) begin errors++; $display("FAIL fwd_adc: got v=%b %h %h %b expected 1 00000000 00000000 1", out_valid, add_a, add_b, add_cin); end
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL fwd_flag: got %b expected 1", carry_flag); end
    step();
    checks++; if (carry_flag !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fwd_drain: got c=%b v=%b expected 0 0", carry_flag, out_valid); end
  endtask

  // SBC with carry 0, ADC with carry 1, then a reserved code as ADD.
  task automatic test_carry_ops();
    drive(1'b1, 3'd3, 32'd9, 32'd4, 1'b1);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    checks++; if (add_a !== 32'd9 || add_b !== 32'hFFFF_FFFB || add_cin !== 1'b0) begin errors++; $display("FAIL sbc_operands: got %h %h %b expected 00000009 fffffffb 0", add_a, add_b, add_cin); end
    step();
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL sbc_carry: got %b expected 1", carry_flag); end
    drive(1'b1, 3'd1, 32'd1, 32'd2, 1'b1);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    checks++; if (add_a !== 32'd1 || add_b !== 32'd2 || add_cin !== 1'b1) begin errors++; $display("FAIL adc_operands: got %h %h %b expected 00000001 00000002 1", add_a, add_b, add_cin); end
    step();
    drive(1'b1, 3'd6, 32'd2, 32'd3, 1'b1);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    checks++; if (add_a !== 32'd2 || add_b !== 32'd3 || add_cin !== 1'b0 || out_cmp !== 1'b0) begin errors++; $display("FAIL rsv_operands: got %h %h %b cmp=%b expected 00000002 00000003 0 0", add_a, add_b, add_cin, out_cmp); end
    step();
  endtask

  // CMP 1-1 would carry out 1; reset must drop it without touching the flag.
  task automatic test_reset_full();
    drive(1'b1, 3'd5, 32'd1, 32'd1, 1'b0);
    step();
    checks++; if (out_valid !== 1'b1 || out_cmp !== 1'b1 || carry_flag !== 1'b0) begin errors++; $display("FAIL rstfull_pre: got v=%b cmp=%b c=%b expected 1 1 0", out_valid, out_cmp, carry_flag); end
    rst = 1'b1;
    drive(1'b1, 3'd0, 32'd4, 32'd4, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    checks++; if (out_valid !== 1'b0 || carry_flag !== 1'b0) begin errors++; $display("FAIL rstfull_post: got v=%b c=%b expected 0 0", out_valid, carry_flag); end
    checks++; if (out_cmp !== 1'b0 || add_a !== 32'd0 || add_b !== 32'd0) begin errors++; $display("FAIL rstfull_regs: got cmp=%b %h %h expected 0 0 0", out_cmp, add_a, add_b); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    out_ready = 1'b0;
    test_reset();
    test_sub();
    test_stall();
    test_neg();
    test_carry_fwd();
    test_carry_ops();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The module SHALL have parameter N, default 32, meaning operand and adder width in bits.
REQ-002 The module SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-003 The module SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1, meaning the request is present.
REQ-005 The module SHALL have port in_ready, output, 1, meaning the stage accepts the request this cycle.
REQ-006 The module SHALL have port in_op, input, 3, meaning the opcode: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 NEG, 5 CMP; 6 and 7 are reserved.
REQ-007 The module SHALL have ports in_a and in_b, input, N each, meaning the raw operands.
REQ-008 The module SHALL have port out_valid, output, 1, meaning the adder operands are held and valid.
REQ-009 The module SHALL have port out_ready, input, 1, meaning downstream consumes the adder result this cycle.
REQ-010 The module SHALL have ports add_a and add_b, output, N each, and add_cin, output, 1, meaning the registered operands and carry-in driven to the adder.
REQ-011 The module SHALL have port add_cout, input, 1, meaning the carry-out returned combinationally by the adder.
REQ-012 The module SHALL have port out_cmp, output, 1, meaning the held operation is CMP, so only flags are written downstream.
REQ-013 The module SHALL have port carry_flag, output, 1, meaning the architectural carry register.

Function
REQ-014 The block SHALL use a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 in_ready SHALL be 1 when EMPTY, or when FULL and out_ready=1, subject to REQ-022.
REQ-016 A transfer SHALL occur when in_valid and in_ready are both 1; the block SHALL then register the operands at that clock edge, so add_a, add_b and add_cin are valid one cycle after acceptance.
REQ-017 The operand mapping SHALL be (a, b, cin):
  - ADD: a, b, 0
  - ADC: a, b, C
  - SUB and CMP: a, ~b, 1
  - SBC: a, ~b, C
  - NEG: 0, ~b, 1
REQ-018 In REQ-017, C SHALL be the effective carry: carry_flag, or add_cout when forwarding applies under REQ-022.
REQ-019 A reserved opcode SHALL be accepted and treated as ADD.
REQ-020 On completion (FULL and out_ready=1), carry_flag SHALL load add_cout for every opcode, including CMP.
REQ-021 FSM transitions:
  - EMPTY to FULL on transfer.
  - FULL to EMPTY on completion without a transfer.
  - FULL stays FULL when completion and transfer coincide.
REQ-022 When completion and transfer of ADC or SBC coincide, the effective carry SHALL come from the configuration in REQ-027.
REQ-023 While FULL and out_ready=0, add_a, add_b, add_cin, out_cmp and carry_flag SHALL hold stable.
REQ-024 Operands SHALL wrap modulo 2^N; the stage SHALL perform no sign extension and no overflow detection.

Reset
REQ-025 A synchronous rst SHALL force the FSM to EMPTY and set out_valid=0, add_a=0, add_b=0, add_cin=0, out_cmp=0 and carry_flag=0.
REQ-026 rst SHALL override any simultaneous transfer or completion, and any held operation SHALL be dropped without a carry update.

Configuration
REQ-027 Macro ALU_OPERAND_CARRY_FWD_EN SHALL control carry forwarding:
  - When defined, an ADC or SBC accepted in the same cycle as a completion SHALL use add_cout as C.
  - When undefined, in_ready SHALL be 0 for ADC and SBC while FULL, so that they accept only from EMPTY using carry_flag; other opcodes SHALL follow REQ-015.

Structure
REQ-028 The opcode encodings, the opcode enum typedef and the default width 32 SHALL live in a shared package, alu_pkg.
REQ-029 Operand formation SHALL be a separate combinational sub-module, alu_operand_mux, mapping (op, a, b, C) to (a, b, cin); the FSM and registers SHALL live in alu_operand_stage.

Verification
REQ-030 The bench SHALL apply reset, then SUB with a=5 and b=3, with out_ready=1, and check one cycle later add_a=5, add_b=0xFFFFFFFC, add_cin=1; after completion it SHALL check carry_flag=1.
REQ-031 The bench SHALL apply NEG with b=1 and check add_a=0, add_b=0xFFFFFFFE, add_cin=1.
REQ-032 The bench SHALL hold out_ready=0 for 4 cycles while FULL with in_valid=1 and check in_ready=0 and that the outputs stay stable, then raise out_ready and check back-to-back acceptance in the same cycle.
REQ-033 The bench SHALL issue ADD 0xFFFFFFFF+1, then ADC 0+0 back-to-back with FWD_EN defined, and check ADC add_cin=1.
REQ-034 With FWD_EN undefined and the same sequence, the bench SHALL check in_ready=0 for ADC for exactly one cycle, then ADC add_cin=1.
REQ-035 The bench SHALL assert rst while FULL with a pending CMP and check out_valid=0 and carry_flag=0 on the next cycle.
